// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with same-cycle write-to-read bypass and a per-register
// busy scoreboard that is set at issue and cleared at write-back.
module regfile_mp_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned INIT_IDX = 1,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_dest,
    output logic [DEPTH-1:0]         busy_vec,
    output logic                     any_busy
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              any_busy_q;
    logic              any_busy_d;
    logic [DEPTH-1:0]  clr_vec;

    // Address is backed by storage: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        addr_ok = ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Write-back updates data and clears busy; a same-cycle issue re-sets busy afterwards.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        clr_vec = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (wr_en[w] && addr_ok(wr_addr[w*ADDR_W +: ADDR_W])) begin
                regs_d[wr_addr[w*ADDR_W +: ADDR_W]]  = wr_data[w*DATA_W +: DATA_W];
                busy_d[wr_addr[w*ADDR_W +: ADDR_W]]  = 1'b0;
                clr_vec[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (iss_en && addr_ok(iss_dest)) begin
            busy_d[iss_dest] = 1'b1;
        end
        any_busy_d = |busy_d;
    end

    // Combinational reads; the highest-indexed matching write port supplies the bypass.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (addr_ok(rd_addr[p*ADDR_W +: ADDR_W])) begin
                rd_data[p*DATA_W +: DATA_W] = regs_q[rd_addr[p*ADDR_W +: ADDR_W]];
                rd_busy[p] = busy_q[rd_addr[p*ADDR_W +: ADDR_W]]
                           & ~clr_vec[rd_addr[p*ADDR_W +: ADDR_W]];
                for (int w = 0; w < int'(NUM_WR); w++) begin
                    if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
                        rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
            end
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign any_busy = any_busy_q;

endmodule
